// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   SZ_B / SZ_H / SZ_W : access size encodings (2'b11 is treated as a word)
//   state_t            : controller sequencing states
//   isMisaligned()     : alignment check for a core access
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    RMW_ISSUE,
    RMW_DATA,
    WR,
    DONE
  } state_t;

  // Halves need an even address; words (and the 2'b11 encoding) need the
  // low two bits clear. Bytes are always aligned.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
    if (size == SZ_B)
      return 1'b0;
    else if (size == SZ_H)
      return lane[0];
    else
      return (lane != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: bundles the core port, the debug/loader port and the memory port
// of the data-memory controller.
//   c_*  : core MEM-stage request/response (byte addressed, any size)
//   d_*  : debug/loader request/response (word only)
//   m_*  : single-ported word-addressed data memory
// Modports: slave = controller view, master = system view (core, debug, memory).
interface dmem_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          c_req;
  logic          c_we;
  logic [1:0]    c_size;
  logic          c_unsigned;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [31:0]   c_rdata;
  logic          c_done;
  logic          c_misalign;
  logic          c_stall;

  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_done;

  logic [AW-1:0] m_addr;
  logic          m_re;
  logic          m_we;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  c_req, c_we, c_size, c_unsigned, c_addr, c_wdata,
    output c_rdata, c_done, c_misalign, c_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_done,
    output m_addr, m_re, m_we, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_size, c_unsigned, c_addr, c_wdata,
    input  c_rdata, c_done, c_misalign, c_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_done,
    input  m_addr, m_re, m_we, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/dmem_lane.sv
// dmem_lane: purely combinational byte-lane logic (little-endian).
//   lane_i       : byte address bits [1:0] of the access
//   size_i       : access size (SZ_B / SZ_H / word)
//   uns_i        : zero-extend instead of sign-extend on loads
//   memWord_i    : word read from memory
//   storeData_i  : right-aligned store data
//   loadData_o   : extracted and extended load result
//   mergedWord_o : memWord_i with the store field inserted at its lane
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] memWord_i,
  input  logic [31:0] storeData_i,
  output logic [31:0] loadData_o,
  output logic [31:0] mergedWord_o
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  // Load path: pick the byte/half at the lane and extend it to 32 bits.
  always_comb begin
    byteVal    = memWord_i[{lane_i, 3'b000} +: 8];
    halfVal    = memWord_i[{lane_i[1], 4'b0000} +: 16];
    loadData_o = memWord_i;
    if (size_i == SZ_B)
      loadData_o = {{24{byteVal[7] & ~uns_i}}, byteVal};
    else if (size_i == SZ_H)
      loadData_o = {{16{halfVal[15] & ~uns_i}}, halfVal};
  end

  // Store path: overwrite only the addressed lane, keep the rest of the word.
  always_comb begin
    mergedWord_o = memWord_i;
    if (size_i == SZ_B)
      mergedWord_o[{lane_i, 3'b000} +: 8] = storeData_i[7:0];
    else if (size_i == SZ_H)
      mergedWord_o[{lane_i[1], 4'b0000} +: 16] = storeData_i[15:0];
    else
      mergedWord_o = storeData_i;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller shared by the core and a debug/loader port.
// Round-robin arbitration in IDLE, sub-word load extraction, read-modify-write
// for sub-word stores and rejection of misaligned core accesses.
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : dmem_if slave modport (core, debug and memory signals)
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic   clock,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  state_t        state_q;
  logic          lastDbg_q;
  logic          isDbg_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] mAddr_q;
  logic [31:0]   storeData_q;
  logic [31:0]   mWdata_q;
  logic [31:0]   cRdata_q;
  logic [31:0]   dRdata_q;
  logic          cDone_q;
  logic          dDone_q;
  logic          misalign_q;
  logic          mRe_q;
  logic          mWe_q;

  logic          pickCore;
  logic          pickDbg;
  logic          selWe;
  logic          selUns;
  logic          selMis;
  logic [1:0]    selSize;
  logic [31:0]   selAddr;
  logic [31:0]   selWdata;
  logic [31:0]   loadVal;
  logic [31:0]   mergedVal;
  logic          unusedAddrBits;

  // On a tie the port that was not granted last wins.
  always_comb begin
    pickCore = 1'b0;
    pickDbg  = 1'b0;
    if (bus.c_req && bus.d_req) begin
      if (lastDbg_q)
        pickCore = 1'b1;
      else
        pickDbg = 1'b1;
    end else if (bus.c_req) begin
      pickCore = 1'b1;
    end else if (bus.d_req) begin
      pickDbg = 1'b1;
    end
  end

  // Debug accesses are always full words and never misaligned.
  always_comb begin
    selWe    = pickDbg ? bus.d_we    : bus.c_we;
    selSize  = pickDbg ? SZ_W        : bus.c_size;
    selUns   = pickDbg ? 1'b0        : bus.c_unsigned;
    selAddr  = pickDbg ? bus.d_addr  : bus.c_addr;
    selWdata = pickDbg ? bus.d_wdata : bus.c_wdata;
    selMis   = pickCore && isMisaligned(bus.c_size, bus.c_addr[1:0]);
  end

  // Address bits above the memory index wrap around.
  assign unusedAddrBits = ^selAddr[31:AW+2];

  dmem_lane uLane (
    .lane_i       (lane_q),
    .size_i       (size_q),
    .uns_i        (uns_q),
    .memWord_i    (bus.m_rdata),
    .storeData_i  (storeData_q),
    .loadData_o   (loadVal),
    .mergedWord_o (mergedVal)
  );

  // Strobes and done pulses are set on the transition into the state that
  // owns them, so every output is a plain register decoded from state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lastDbg_q   <= 1'b1;
      isDbg_q     <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_B;
      lane_q      <= 2'b00;
      mAddr_q     <= '0;
      storeData_q <= '0;
      mWdata_q    <= '0;
      cRdata_q    <= '0;
      dRdata_q    <= '0;
      cDone_q     <= 1'b0;
      dDone_q     <= 1'b0;
      misalign_q  <= 1'b0;
      mRe_q       <= 1'b0;
      mWe_q       <= 1'b0;
    end else begin
      cDone_q    <= 1'b0;
      dDone_q    <= 1'b0;
      misalign_q <= 1'b0;
      mRe_q      <= 1'b0;
      mWe_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pickCore || pickDbg) begin
            isDbg_q     <= pickDbg;
            lastDbg_q   <= pickDbg;
            uns_q       <= selUns;
            size_q      <= selSize;
            lane_q      <= selAddr[1:0];
            storeData_q <= selWdata;
            mAddr_q     <= selAddr[AW+1:2];
            if (selMis) begin
              cRdata_q   <= '0;
              cDone_q    <= 1'b1;
              misalign_q <= 1'b1;
              state_q    <= DONE;
            end else if (!selWe) begin
              mRe_q   <= 1'b1;
              state_q <= RD_ISSUE;
            end else if (selSize == SZ_B || selSize == SZ_H) begin
              mRe_q   <= 1'b1;
              state_q <= RMW_ISSUE;
            end else begin
              mWe_q    <= 1'b1;
              mWdata_q <= selWdata;
              state_q  <= WR;
            end
          end
        end
        RD_ISSUE: state_q <= RD_DATA;
        RD_DATA: begin
          if (isDbg_q)
            dRdata_q <= loadVal;
          else
            cRdata_q <= loadVal;
          cDone_q <= ~isDbg_q;
          dDone_q <= isDbg_q;
          state_q <= DONE;
        end
        RMW_ISSUE: state_q <= RMW_DATA;
        RMW_DATA: begin
          mWdata_q <= mergedVal;
          mWe_q    <= 1'b1;
          state_q  <= WR;
        end
        WR: begin
          cDone_q <= ~isDbg_q;
          dDone_q <= isDbg_q;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.c_rdata    = cRdata_q;
  assign bus.c_done     = cDone_q;
  assign bus.c_misalign = misalign_q;
  assign bus.c_stall    = bus.c_req & ~cDone_q;
  assign bus.d_rdata    = dRdata_q;
  assign bus.d_done     = dDone_q;
  assign bus.m_addr     = mAddr_q;
  assign bus.m_re       = mRe_q;
  assign bus.m_we       = mWe_q;
  assign bus.m_wdata    = mWdata_q;

endmodule
